// File: rtl/conv55_seq_ctrl.sv
// conv55_seq_ctrl: byte-stream sequencer for the 5x5 convolution engine.
// A kernel load (25 weights) is followed by any number of 25-pixel windows.
// Both operand sets are held in registers feeding the purely combinational
// engine. The engine sum is captured ENG_LAT cycles after the last pixel and
// returned on a valid/ready output port.
module conv55_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TAPS    = 25,
  parameter int OUT_W   = 18,
  parameter int ENG_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     kload,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic [TAPS*DATA_W-1:0]   kernel_bus,
  output logic [TAPS*DATA_W-1:0]   window_bus,
  input  logic [OUT_W-1:0]         eng_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     k_loaded,
  output logic                     busy
);

  localparam int BUS_W = TAPS * DATA_W;
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] FIRST_NXT = CNT_W'(1);
  localparam logic [3:0] LAT_INIT = 4'(ENG_LAT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_K = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] tap_cnt;
  logic [3:0]       wait_cnt;
  logic             in_fire;
  logic             out_fire;
  logic             last_tap;
  logic             capture;

  // Replace one DATA_W lane of a packed operand bus; other lanes untouched.
  function automatic logic [BUS_W-1:0] put_tap(
    input logic [BUS_W-1:0]  bus,
    input logic [CNT_W-1:0]  idx,
    input logic [DATA_W-1:0] val
  );
    logic [BUS_W-1:0] res;
    res = bus;
    for (int i = 0; i < TAPS; i++) begin
      if (idx == CNT_W'(i)) begin
        res[i*DATA_W +: DATA_W] = val;
      end
    end
    return res;
  endfunction

  // Input acceptance: kload wins over a simultaneous pixel in IDLE, and
  // pixels are refused until a complete kernel is resident.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:   in_ready = k_loaded & ~kload;
      S_LOAD_K: in_ready = 1'b1;
      S_LOAD_W: in_ready = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  // Handshake and sequencing qualifiers shared by the registered logic.
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    last_tap = (tap_cnt == LAST_TAP);
    capture  = (state == S_WAIT) && (wait_cnt == 4'd1);
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (kload) begin
          state_nxt = S_LOAD_K;
        end else if (in_fire) begin
          state_nxt = S_LOAD_W;
        end
      end
      S_LOAD_K: begin
        if (in_fire && last_tap) begin
          state_nxt = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (in_fire && last_tap) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (capture) begin
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_fire) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and busy flag; busy mirrors the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  // Tap counter: advances only on accepted bytes; tap 0 of a window is
  // taken in IDLE, so the window count resumes at 1 in LOAD_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (kload) begin
            tap_cnt <= '0;
          end else if (in_fire) begin
            tap_cnt <= FIRST_NXT;
          end
        end
        S_LOAD_K, S_LOAD_W: begin
          if (in_fire) begin
            tap_cnt <= last_tap ? '0 : tap_cnt + FIRST_NXT;
          end
        end
        default: tap_cnt <= tap_cnt;
      endcase
    end
  end

  // Engine settling counter, armed by the last pixel of a window.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == S_LOAD_W) && in_fire && last_tap) begin
      wait_cnt <= LAT_INIT;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Kernel residency: cleared when a reload starts, set by weight 24.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_loaded <= 1'b0;
    end else if ((state == S_IDLE) && kload) begin
      k_loaded <= 1'b0;
    end else if ((state == S_LOAD_K) && in_fire && last_tap) begin
      k_loaded <= 1'b1;
    end
  end

  // Weight register file; window traffic never touches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      kernel_bus <= '0;
    end else if ((state == S_LOAD_K) && in_fire) begin
      kernel_bus <= put_tap(kernel_bus, tap_cnt, in_data);
    end
  end

  // Pixel register file; every window rewrites all taps from tap 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      window_bus <= '0;
    end else if ((state == S_IDLE) && in_fire) begin
      window_bus <= put_tap(window_bus, '0, in_data);
    end else if ((state == S_LOAD_W) && in_fire) begin
      window_bus <= put_tap(window_bus, tap_cnt, in_data);
    end
  end

  // Result register: engine sum taken as-is, held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= eng_sum;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv55_seq_ctrl.sv
// Directed bench for conv55_seq_ctrl with a behavioural 5x5 MAC engine.
module tb_conv55_seq_ctrl;

  localparam int DATA_W  = 8;
  localparam int TAPS    = 25;
  localparam int OUT_W   = 18;
  localparam int ENG_LAT = 1;
  localparam int BW      = TAPS * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              kload;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [BW-1:0]     kernel_bus;
  logic [BW-1:0]     window_bus;
  logic [OUT_W-1:0]  eng_sum;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              k_loaded;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  conv55_seq_ctrl #(
    .DATA_W(DATA_W), .TAPS(TAPS), .OUT_W(OUT_W), .ENG_LAT(ENG_LAT)
  ) dut (
    .clk(clk), .rst(rst), .kload(kload),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .kernel_bus(kernel_bus), .window_bus(window_bus), .eng_sum(eng_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .k_loaded(k_loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational engine: sum of 25 byte products, truncated to OUT_W.
  logic [31:0] acc;
  always_comb begin
    acc = 32'd0;
    for (int i = 0; i < TAPS; i++) begin
      acc = acc + 32'(kernel_bus[i*DATA_W +: DATA_W]) * 32'(window_bus[i*DATA_W +: DATA_W]);
    end
    eng_sum = acc[OUT_W-1:0];
  end

  typedef struct {
    string name;
    int    reload;   // 1: load a fresh kernel before the window
    int    wramp;    // 1: weight i = i, else all weights = wval
    int    wval;
    int    pval;     // every pixel of the window
    int    gaps;     // 1: idle cycle between pixels
    int    hold;     // cycles out_ready stays low once out_valid rises
    int    kl_tap;   // pixel index sent with kload high, -1 for none
    int    exp_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and return just after the edge that accepts it.
  task automatic send_byte(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_weights(input int wramp, input int wval);
    for (int t = 0; t < TAPS; t++) begin
      send_byte(wramp != 0 ? 8'(t) : 8'(wval));
    end
    chk("k_loaded_after_load", BW'(k_loaded), BW'(1));
    chk("busy_after_load", BW'(busy), BW'(0));
    chk("in_ready_after_load", BW'(in_ready), BW'(1));
  endtask

  task automatic load_kernel(input int wramp, input int wval);
    kload = 1'b1;
    tick();
    kload = 1'b0;
    chk("kload_busy", BW'(busy), BW'(1));
    chk("kload_clears_k_loaded", BW'(k_loaded), BW'(0));
    send_weights(wramp, wval);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, BW'(in_ready), BW'(0));
    chk({tag, "_kernel_bus"}, kernel_bus, BW'(0));
    chk({tag, "_window_bus"}, window_bus, BW'(0));
    chk({tag, "_out_valid"}, BW'(out_valid), BW'(0));
    chk({tag, "_out_data"}, BW'(out_data), BW'(0));
    chk({tag, "_k_loaded"}, BW'(k_loaded), BW'(0));
    chk({tag, "_busy"}, BW'(busy), BW'(0));
  endtask

  task automatic run_vec(input vec_t v);
    logic [BW-1:0] kexp;
    logic [BW-1:0] wexp;
    int n;
    for (int t = 0; t < TAPS; t++) begin
      kexp[t*DATA_W +: DATA_W] = (v.wramp != 0) ? 8'(t) : 8'(v.wval);
      wexp[t*DATA_W +: DATA_W] = 8'(v.pval);
    end
    if (v.reload != 0) load_kernel(v.wramp, v.wval);
    for (int t = 0; t < TAPS; t++) begin
      if (v.gaps != 0 && t > 0) tick();
      if (t == v.kl_tap) kload = 1'b1;
      send_byte(8'(v.pval));
      kload = 1'b0;
      if (t == v.kl_tap) begin
        chk({v.name, "_kload_ignored_busy"}, BW'(busy), BW'(1));
        chk({v.name, "_kload_ignored_kl"}, BW'(k_loaded), BW'(1));
      end
    end
    chk({v.name, "_wait_out_valid"}, BW'(out_valid), BW'(0));
    chk({v.name, "_wait_in_ready"}, BW'(in_ready), BW'(0));
    chk({v.name, "_wait_busy"}, BW'(busy), BW'(1));
    chk({v.name, "_window_bus"}, window_bus, wexp);
    out_ready = (v.hold == 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({v.name, "_latency"}, BW'(n), BW'(ENG_LAT));
    chk({v.name, "_out_data"}, BW'(out_data), BW'(v.exp_sum));
    for (int h = 0; h < v.hold; h++) begin
      chk({v.name, "_hold_valid"}, BW'(out_valid), BW'(1));
      chk({v.name, "_hold_data"}, BW'(out_data), BW'(v.exp_sum));
      chk({v.name, "_hold_in_ready"}, BW'(in_ready), BW'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk({v.name, "_valid_dropped"}, BW'(out_valid), BW'(0));
    chk({v.name, "_idle_busy"}, BW'(busy), BW'(0));
    chk({v.name, "_idle_in_ready"}, BW'(in_ready), BW'(1));
    chk({v.name, "_k_loaded"}, BW'(k_loaded), BW'(1));
    chk({v.name, "_kernel_bus"}, kernel_bus, kexp);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] exp_bus;
    vecs[0] = '{"basic",      1, 0, 1,   1,   0, 0, -1, 25};
    vecs[1] = '{"weighted",   1, 1, 0,   2,   0, 0, -1, 600};
    vecs[2] = '{"zero_win",   0, 1, 0,   0,   0, 0, -1, 0};
    vecs[3] = '{"wrap",       1, 0, 255, 255, 0, 0, -1, 52761};
    vecs[4] = '{"gaps_bp",    0, 0, 255, 1,   1, 5, -1, 6375};
    vecs[5] = '{"kload_in_w", 0, 0, 255, 3,   0, 0, 10, 19125};

    rst = 1'b1; kload = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs("reset");

    // Pixel offered before any kernel is refused.
    in_valid = 1'b1;
    in_data  = 8'h5a;
    #1;
    chk("no_kernel_in_ready", BW'(in_ready), BW'(0));
    repeat (2) tick();
    chk("no_kernel_busy", BW'(busy), BW'(0));
    chk("no_kernel_window", window_bus, BW'(0));
    in_valid = 1'b0;

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // kload and a pixel together in IDLE: the pixel is not taken.
    for (int t = 0; t < TAPS; t++) exp_bus[t*DATA_W +: DATA_W] = 8'd3;
    in_valid = 1'b1;
    in_data  = 8'h77;
    kload    = 1'b1;
    #1;
    chk("prio_in_ready", BW'(in_ready), BW'(0));
    tick();
    kload    = 1'b0;
    in_valid = 1'b0;
    chk("prio_busy", BW'(busy), BW'(1));
    chk("prio_k_loaded", BW'(k_loaded), BW'(0));
    chk("prio_window_kept", window_bus, exp_bus);
    send_weights(0, 2);
    for (int t = 0; t < TAPS; t++) exp_bus[t*DATA_W +: DATA_W] = 8'd2;
    chk("prio_kernel_bus", kernel_bus, exp_bus);

    // Reset part-way through a window drops everything, kernel included.
    for (int t = 0; t < 12; t++) send_byte(8'd5);
    chk("mid_busy", BW'(busy), BW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    in_valid = 1'b1;
    in_data  = 8'h09;
    #1;
    chk("midrst_refuse", BW'(in_ready), BW'(0));
    repeat (3) tick();
    chk("midrst_window", window_bus, BW'(0));
    chk("midrst_busy", BW'(busy), BW'(0));
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv55_seq_ctrl.md
# conv55_seq_ctrl

Sequencer for the 5x5 convolution engine (25 8-bit multipliers feeding an 18-bit adder tree).
- Loads the 25 kernel weights from a byte stream, then gathers 25-pixel windows from the same stream.
- Holds both operand sets stable in registers while the engine settles, captures the engine sum, and returns it on a valid/ready output.
- Sits between the LeNet-5 layer scheduler and one engine instance; the engine itself stays purely combinational.

## Interface
Parameters:
- DATA_W, 8, operand width (pixel and weight).
- TAPS, 25, operands per window/kernel.
- OUT_W, 18, engine sum width.
- ENG_LAT, 1, cycles from operand-register update to sum capture (range 1..15).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- kload  in  1  pulse: begin kernel load; honoured only in IDLE.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid & in_ready.
- in_data  in  DATA_W  kernel weight (LOAD_K) or pixel (IDLE/LOAD_W), tap order 0..24.
- kernel_bus  out  TAPS*DATA_W  registered weights; tap i at [i*8+7:i*8], to engine kernel_i.
- window_bus  out  TAPS*DATA_W  registered pixels; same packing, to engine in_data_i.
- eng_sum  in  OUT_W  engine result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  captured result.
- k_loaded  out  1  full kernel resident.
- busy  out  1  state != IDLE.

Reset values: in_ready=0, kernel_bus=0, window_bus=0, out_valid=0, out_data=0, k_loaded=0, busy=0.

## Operation
States:
- **IDLE**
  - kload=1 → LOAD_K: tap count cleared, k_loaded cleared.
  - Otherwise in_ready = k_loaded. An accepted byte is written to window tap 0, count=1, → LOAD_W.
  - kload has priority: if kload and in_valid are both high, in_ready=0 that cycle.
- **LOAD_K**
  - in_ready=1. Each accepted byte is written to kernel tap[count], count++.
  - On acceptance of tap 24: k_loaded=1, → IDLE.
- **LOAD_W**
  - in_ready=1. Each accepted byte is written to window tap[count], count++.
  - On acceptance of tap 24: wait counter = ENG_LAT, → WAIT.
- **WAIT**
  - in_ready=0. Counter decrements each cycle.
  - When counter==1: out_data ← eng_sum, out_valid=1, → OUT.
- **OUT**
  - in_ready=0. out_valid and out_data are held stable until out_ready.
  - On handshake: out_valid=0, → IDLE.

Rules:
- kload outside IDLE is ignored (no queueing).
- Window taps are fully overwritten on every window; stale taps are never reused. kernel_bus is unchanged by window traffic.
- Arithmetic is the engine's. out_data is eng_sum as presented (mod 2^OUT_W); the controller performs no widening or saturation.
- in_valid gaps are allowed anywhere in LOAD_K/LOAD_W; the count advances only on handshake.
- Reset mid-operation (any state): next cycle is IDLE with all reset values, kernel discarded (k_loaded=0), and any pending result dropped.

## Timing
- Bus updates: kernel_bus/window_bus change only at the edge where the corresponding byte is accepted.
- Result capture: if the last pixel is accepted at edge E, out_data is captured and out_valid rises at edge E+ENG_LAT.
- Output latency: with out_ready held high, out_valid is high for exactly one cycle.
- Earliest next acceptance: in_ready may rise in the cycle after the output handshake edge.
- Minimum window period: 25 + ENG_LAT + 1 cycles with continuous in_valid and out_ready.
- Kernel load: takes 25 accepted bytes. The first pixel may be accepted in the cycle after the tap-24 edge.
- Status timing: busy and k_loaded are registered, updated at the same edges as state.

## Test plan
- **Basic window:** reset; kload; weights 1×25; pixels 1×25, out_ready=1 → out_data=25, out_valid one cycle at E+1, k_loaded=1 throughout.
- **Weighted sum:** weights w_i=i, pixels all 2 → out_data=600. Second window with pixels all 0 and no reload → out_data=0, kernel_bus unchanged.
- **Wrap:** weights and pixels all 255 → out_data=52761 (1,625,625 mod 2^18). No other flags.
- **Backpressure and gaps:** in_valid toggling 1/0 during the window; out_ready low 5 cycles after out_valid → out_data stable, in_ready=0 while out_valid, single transfer on release.
- **Priority and ignore:**
  - Pixel before any kernel → in_ready=0.
  - kload+in_valid together in IDLE → byte not accepted, LOAD_K entered.
  - kload during LOAD_W → ignored, window result correct.
- **Reset mid-operation:** assert rst after 12 window pixels → next cycle all outputs at reset values, k_loaded=0. Pixels then refused until a new kernel load.
